// File: rtl/veopixel_decoder.sv
// veopixel_decoder: one-wire pixel line decoder that captures its own 24-bit word,
// forwards the rest of the frame on DO, and re-arms on a long-low latch code.
module veopixel_decoder #(
    parameter int MIN_HIGH     = 5,
    parameter int BIT_THRESH   = 30,
    parameter int MAX_HIGH     = 60,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DI,
    output logic [23:0] pixel_data,
    output logic        pixel_valid,
    output logic        DO,
    output logic        latch,
    output logic        bit_error
);
    localparam int LW = $clog2(LATCH_CYCLES + 1);
    localparam logic [LW-1:0] LATCH_V = LW'(LATCH_CYCLES);
    localparam logic [7:0] MIN_V = 8'(MIN_HIGH);
    localparam logic [7:0] THRESH_V = 8'(BIT_THRESH);
    localparam logic [7:0] MAX_V = 8'(MAX_HIGH);

    typedef enum logic [1:0] {CAPTURE, PASS, ERROR} state_t;

    state_t state_q, state_d;
    logic sync_q, di_s_q, di_p_q;
    logic [7:0] high_cnt_q, high_cnt_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [23:0] shift_q, shift_d, pixel_data_q, pixel_data_d;
    logic valid_q, valid_d, latch_q, latch_d, err_q, err_d, do_q, do_d;
    logic rise, fall, latch_hit, cap_fall, err_ev, shift_ev, word_done, bit_v;

    assign rise      = di_s_q & ~di_p_q;
    assign fall      = ~di_s_q & di_p_q;
    assign bit_v     = high_cnt_q >= THRESH_V;
    assign latch_hit = (low_cnt_d == LATCH_V) && (low_cnt_q != LATCH_V);
    // Glitches (too-short highs) are filtered here so they never touch the FSM.
    assign cap_fall  = (state_q == CAPTURE) && fall && (high_cnt_q >= MIN_V);
    assign err_ev    = cap_fall && (high_cnt_q > MAX_V);
    assign shift_ev  = cap_fall && !(high_cnt_q > MAX_V);
    assign word_done = shift_ev && (bit_cnt_q == 5'd23);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = latch_hit ? CAPTURE :
                  err_ev    ? ERROR   :
                  word_done ? PASS    : state_q;
    end

    always_comb begin
        high_cnt_d   = !di_s_q ? high_cnt_q : rise ? 8'd1 :
                       (high_cnt_q == 8'hFF) ? 8'hFF : high_cnt_q + 8'd1;
        low_cnt_d    = di_s_q ? '0 : (low_cnt_q == LATCH_V) ? LATCH_V : low_cnt_q + 1'b1;
        shift_d      = (latch_hit || err_ev || word_done) ? 24'd0 :
                       shift_ev ? {shift_q[22:0], bit_v} : shift_q;
        bit_cnt_d    = (latch_hit || err_ev || word_done) ? 5'd0 :
                       shift_ev ? bit_cnt_q + 5'd1 : bit_cnt_q;
        pixel_data_d = word_done ? {shift_q[22:0], bit_v} : pixel_data_q;
        valid_d      = word_done && !latch_hit;
        err_d        = err_ev && !latch_hit;
        latch_d      = latch_hit;
        do_d         = (state_q == PASS) && !latch_hit && di_s_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 1'b0;
            di_s_q       <= 1'b0;
            di_p_q       <= 1'b0;
            high_cnt_q   <= 8'd0;
            low_cnt_q    <= '0;
            bit_cnt_q    <= 5'd0;
            shift_q      <= 24'd0;
            pixel_data_q <= 24'd0;
            valid_q      <= 1'b0;
            latch_q      <= 1'b0;
            err_q        <= 1'b0;
            do_q         <= 1'b0;
        end else begin
            sync_q       <= DI;
            di_s_q       <= sync_q;
            di_p_q       <= di_s_q;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pixel_data_q <= pixel_data_d;
            valid_q      <= valid_d;
            latch_q      <= latch_d;
            err_q        <= err_d;
            do_q         <= do_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_valid = valid_q;
    assign latch       = latch_q;
    assign bit_error   = err_q;
    assign DO          = do_q;
endmodule
